// File: rtl/pixel_engine_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pixel_engine_scheduler
// Purpose : Round-robin dispatch of raster pixels to escape-time engines and
//           raster-ordered re-emission of their iteration counts.
// Rev     : 1.0  initial release
// ============================================================================
module pixel_engine_scheduler #(
    parameter int NUM_ENGINES = 2,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int ITER_W      = 8
) (
    input  logic                          out_stream_aclk,
    input  logic                          periph_reset,
    input  logic                          ctrl_run,
    output logic                          ctrl_busy,
    output logic                          ctrl_frame_done,
    output logic [15:0]                   ctrl_frame_cnt,
    output logic                          err_spurious,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [9:0]                    eng_x,
    output logic [8:0]                    eng_y,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic                          pix_valid,
    output logic [ITER_W-1:0]             pix_iter,
    output logic                          pix_sof,
    output logic                          pix_eol,
    input  logic                          pix_ready
);

    localparam int                 c_PTR_W    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NUM_ENGINES - 1);
    localparam logic [9:0]         c_X_LAST   = 10'(X_SIZE - 1);
    localparam logic [8:0]         c_Y_LAST   = 9'(Y_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;
    typedef enum logic [1:0] {SL_IDLE = 2'd0, SL_RUNNING = 2'd1, SL_DONE = 2'd2} slot_t;

    state_t               r_state, w_state_n;
    slot_t                r_slot   [NUM_ENGINES];
    slot_t                w_slot_n [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] r_stale, w_stale_n, w_start_n;
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr, w_wr_n, w_rd_n;
    logic [9:0]           r_x, r_ox, w_x_n, w_ox_n;
    logic [8:0]           r_y, r_oy, w_y_n, w_oy_n;
    logic                 w_xfer, w_dispatch, w_last_disp, w_last_out, w_valid_n, w_err_n;
    logic [ITER_W-1:0]    w_iter_n;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_xfer      = pix_valid & pix_ready;
        w_dispatch  = ((r_state == S_RUN) || ((r_state == S_IDLE) && ctrl_run))
                      && (r_slot[r_wr_ptr] == SL_IDLE);
        w_last_disp = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
        w_last_out  = (r_ox == c_X_LAST) && (r_oy == c_Y_LAST);

        w_wr_n = w_dispatch ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_n = w_xfer ? ptr_inc(r_rd_ptr) : r_rd_ptr;

        w_x_n = r_x;
        w_y_n = r_y;
        if (w_dispatch) begin
            w_x_n = (r_x == c_X_LAST) ? '0 : r_x + 10'd1;
            if (r_x == c_X_LAST)
                w_y_n = (r_y == c_Y_LAST) ? '0 : r_y + 9'd1;
        end
        w_ox_n = r_ox;
        w_oy_n = r_oy;
        if (w_xfer) begin
            w_ox_n = (r_ox == c_X_LAST) ? '0 : r_ox + 10'd1;
            if (r_ox == c_X_LAST)
                w_oy_n = (r_oy == c_Y_LAST) ? '0 : r_oy + 9'd1;
        end

        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (ctrl_run) w_state_n = S_RUN;
            S_RUN:   if (w_dispatch && w_last_disp && !ctrl_run) w_state_n = S_DRAIN;
            S_DRAIN: if (w_xfer && w_last_out) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase

        w_start_n = '0;
        if (w_dispatch)
            w_start_n[r_wr_ptr] = 1'b1;

        // A stale slot absorbs one completion from an engine launched before reset.
        w_err_n   = err_spurious;
        w_stale_n = r_stale;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            w_slot_n[k] = r_slot[k];
            if (eng_done[k]) begin
                if (r_slot[k] == SL_RUNNING)
                    w_slot_n[k] = SL_DONE;
                else if (r_stale[k])
                    w_stale_n[k] = 1'b0;
                else
                    w_err_n = 1'b1;
            end
            if (w_xfer && (r_rd_ptr == c_PTR_W'(k)))
                w_slot_n[k] = SL_IDLE;
            if (w_dispatch && (r_wr_ptr == c_PTR_W'(k))) begin
                w_slot_n[k]  = SL_RUNNING;
                w_stale_n[k] = 1'b0;
            end
        end

        w_valid_n = (w_slot_n[w_rd_n] == SL_DONE);
        w_iter_n  = w_valid_n ? eng_iter[int'(w_rd_n)*ITER_W +: ITER_W] : '0;
    end

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            r_state <= S_IDLE;
            for (int k = 0; k < NUM_ENGINES; k++)
                r_slot[k] <= SL_IDLE;
            r_stale         <= '1;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_ox            <= '0;
            r_oy            <= '0;
            ctrl_busy       <= 1'b0;
            ctrl_frame_done <= 1'b0;
            ctrl_frame_cnt  <= '0;
            err_spurious    <= 1'b0;
            eng_start       <= '0;
            eng_x           <= '0;
            eng_y           <= '0;
            pix_valid       <= 1'b0;
            pix_iter        <= '0;
            pix_sof         <= 1'b0;
            pix_eol         <= 1'b0;
        end else begin
            r_state <= w_state_n;
            for (int k = 0; k < NUM_ENGINES; k++)
                r_slot[k] <= w_slot_n[k];
            r_stale         <= w_stale_n;
            r_wr_ptr        <= w_wr_n;
            r_rd_ptr        <= w_rd_n;
            r_x             <= w_x_n;
            r_y             <= w_y_n;
            r_ox            <= w_ox_n;
            r_oy            <= w_oy_n;
            ctrl_busy       <= (w_state_n != S_IDLE);
            ctrl_frame_done <= w_xfer && w_last_out;
            if (w_xfer && w_last_out)
                ctrl_frame_cnt <= ctrl_frame_cnt + 16'd1;
            err_spurious    <= w_err_n;
            eng_start       <= w_start_n;
            eng_x           <= w_dispatch ? r_x : '0;
            eng_y           <= w_dispatch ? r_y : '0;
            pix_valid       <= w_valid_n;
            pix_iter        <= w_iter_n;
            pix_sof         <= w_valid_n && (w_ox_n == '0) && (w_oy_n == '0);
            pix_eol         <= w_valid_n && (w_ox_n == c_X_LAST);
        end
    end

endmodule
`default_nettype wire
